raiz_arbiter: RTL and testbench

Shares one square-root core (16-bit operand, 8-bit root, start/done handshake) among N_REQ requesters. It arbitrates round-robin and latches the winning operand. For each job it clears the core, launches it, waits for done with a timeout watchdog, then returns the result with a one-cycle acknowledge to the winner. It sits between the pixel/compute clients and the core, so clients never drive the core directly.

---
 rtl/raiz_pkg.sv | 27 ++
 rtl/rr_picker.sv | 35 +++
 rtl/raiz_arbiter.sv | 128 ++++++++++++
 tb/tb_raiz_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raiz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | raiz_pkg : shared types and defaults for the square-root arbiter      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package raiz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_WAIT     = 3'd3,
    ST_COMPLETE = 3'd4,
    ST_ABORT    = 3'd5
  } state_t;

  localparam int c_n_req   = 4;
  localparam int c_op_w    = 16;
  localparam int c_timeout = 64;

  // Index/counter width; never below one bit so a 2-entry space still has a register.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_picker : combinational round-robin winner search from a pointer   |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_picker
  import raiz_pkg::*;
#(
  parameter int  N_REQ = c_n_req,
  localparam int IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_pos = '0;
    // Walk from the far end back toward ptr so the nearest requester is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[w_pos]) begin
        valid = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/raiz_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | raiz_arbiter : round-robin sharing of one square-root core            |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module raiz_arbiter
  import raiz_pkg::*;
#(
  parameter int  N_REQ   = c_n_req,
  parameter int  OP_W    = c_op_w,
  parameter int  TIMEOUT = c_timeout,
  localparam int RES_W   = OP_W / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      in_req,
  input  logic [N_REQ*OP_W-1:0] in_A,
  output logic [N_REQ-1:0]      out_ack,
  output logic                  out_err,
  output logic [RES_W-1:0]      out_result,
  output logic                  out_busy,
  output logic                  out_raiz_rst,
  output logic                  out_raiz_init,
  output logic [OP_W-1:0]       out_raiz_A,
  input  logic                  in_raiz_done,
  input  logic [RES_W-1:0]      in_raiz_result
);

  localparam int IDX_W = clog2_min1(N_REQ);
  localparam int CNT_W = clog2_min1(TIMEOUT);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_REQ - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [OP_W-1:0]  r_operand;
  logic [RES_W-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;

  logic             w_valid;
  logic [IDX_W-1:0] w_win;
  logic [OP_W-1:0]  w_win_operand;
  logic [IDX_W-1:0] w_ptr_next;
  logic [N_REQ-1:0] w_ack_onehot;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req   (in_req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_win)
  );

  assign w_win_operand = in_A[w_win*OP_W +: OP_W];
  assign w_ptr_next    = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
  assign w_ack_onehot  = N_REQ'(1) << r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_operand <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_idx     <= w_win;
            r_operand <= w_win_operand;
            r_state   <= ST_GRANT;
          end
        end
        ST_GRANT: r_state <= ST_LAUNCH;
        ST_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A done arriving on the last watchdog cycle still counts as success.
          if (in_raiz_done) begin
            r_result <= in_raiz_result;
            r_state  <= ST_COMPLETE;
          end else if (r_cnt == c_cnt_last) begin
            r_state <= ST_ABORT;
          end
        end
        ST_COMPLETE, ST_ABORT: begin
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on the request inputs.
  always_comb begin
    out_ack       = '0;
    out_err       = 1'b0;
    out_result    = '0;
    out_busy      = (r_state != ST_IDLE);
    out_raiz_rst  = 1'b0;
    out_raiz_init = 1'b0;
    case (r_state)
      ST_IDLE, ST_GRANT: out_raiz_rst = 1'b1;
      ST_LAUNCH:         out_raiz_init = 1'b1;
      ST_COMPLETE: begin
        out_ack    = w_ack_onehot;
        out_result = r_result;
      end
      ST_ABORT: begin
        out_ack = w_ack_onehot;
        out_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_raiz_A = r_operand;

endmodule
`default_nettype wire

// File: tb/tb_raiz_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_raiz_arbiter : self-checking bench with job-schedule model        |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_raiz_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int R = 8;
  localparam int T = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_bus = '0;
  logic [N-1:0]   ack;
  logic           err;
  logic [R-1:0]   res;
  logic           busy, raiz_rst, raiz_init;
  logic [W-1:0]   raiz_A;

  // Behavioural core: done rises core_delay cycles after init, held until cleared.
  logic         core_done = 1'b0;
  logic [R-1:0] core_res  = '0;
  logic         core_run  = 1'b0;
  logic [W-1:0] core_op   = '0;
  int           core_cnt  = 0;
  int           core_delay = -1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one job at a time, expected schedule from the timing rules.
  bit           m_active = 1'b0;
  int           m_t, m_ack, m_w;
  int           m_ptr = 0;
  int           m_free_from = 0;
  bit           m_err;
  logic [W-1:0] m_a;
  logic [W-1:0] m_lastA = '0;
  logic [R-1:0] m_res;
  int           next_delay = -2;
  int           stim_mode = 0;
  int           hold[N];

  int           dut_ack_cnt = 0;
  logic [N-1:0] last_ack = '0;
  logic [R-1:0] last_res = '0;
  logic         last_err = 1'b0;
  int           last_cyc = 0;

  typedef struct {
    int idx;
    int a;
    int d;
    int exp_res;
    int exp_err;
    int exp_lat;
  } vec_t;

  vec_t tbl[7];

  raiz_arbiter #(
    .N_REQ   (N),
    .OP_W    (W),
    .TIMEOUT (T)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_req         (req),
    .in_A           (a_bus),
    .out_ack        (ack),
    .out_err        (err),
    .out_result     (res),
    .out_busy       (busy),
    .out_raiz_rst   (raiz_rst),
    .out_raiz_init  (raiz_init),
    .out_raiz_A     (raiz_A),
    .in_raiz_done   (core_done),
    .in_raiz_result (core_res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int isqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  always @(posedge clk) begin
    if (raiz_rst) begin
      core_done <= 1'b0;
      core_run  <= 1'b0;
    end else if (raiz_init) begin
      core_run <= 1'b1;
      core_cnt <= core_delay;
      core_op  <= raiz_A;
    end else if (core_run && core_cnt >= 1) begin
      if (core_cnt == 1) begin
        core_done <= 1'b1;
        core_res  <= R'(isqrt(int'(core_op)));
        core_run  <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  function automatic int pick_delay();
    int r = $urandom_range(15);
    if (r == 0) return -1;
    if (r == 1) return T - 1;
    if (r == 2) return T;
    return $urandom_range(30, 1);
  endfunction

  task automatic cmp_val(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model_arbitrate();
    int w;
    int d;
    if (!m_active && cyc >= m_free_from && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      d = (next_delay == -2) ? pick_delay() : next_delay;
      m_active   = 1'b1;
      m_t        = cyc;
      m_w        = w;
      m_a        = a_bus[w*W +: W];
      m_lastA    = m_a;
      core_delay = d;
      if (d >= 1 && d <= T - 1) begin
        m_err = 1'b0;
        m_ack = cyc + 4 + d;
        m_res = R'(isqrt(int'(m_a)));
      end else begin
        m_err = 1'b1;
        m_ack = cyc + 3 + T;
        m_res = '0;
      end
    end
  endtask

  task automatic check();
    logic [N-1:0] e_ack;
    logic         e_err, e_busy, e_rst, e_init;
    logic [R-1:0] e_res;
    logic [W-1:0] e_A;
    e_ack = '0; e_err = 1'b0; e_res = '0; e_init = 1'b0;
    if (m_active) begin
      e_busy = 1'b1;
      e_rst  = (cyc == m_t + 1);
      e_init = (cyc == m_t + 2);
      e_A    = m_a;
      if (cyc == m_ack) begin
        e_ack = 4'b0001 << m_w;
        e_err = m_err;
        e_res = m_res;
      end
    end else begin
      e_busy = 1'b0;
      e_rst  = 1'b1;
      e_A    = m_lastA;
    end
    n_cmp++;
    if ({ack, err, res, busy, raiz_rst, raiz_init, raiz_A} !==
        {e_ack, e_err, e_res, e_busy, e_rst, e_init, e_A}) begin
      n_bad++;
      $display("FAIL cyc%0d outputs: got ack=%b err=%b res=%0d busy=%b rrst=%b init=%b A=%h, want ack=%b err=%b res=%0d busy=%b rrst=%b init=%b A=%h",
               cyc, ack, err, res, busy, raiz_rst, raiz_init, raiz_A,
               e_ack, e_err, e_res, e_busy, e_rst, e_init, e_A);
    end
    if (ack != '0) begin
      dut_ack_cnt++;
      last_ack = ack;
      last_res = res;
      last_err = err;
      last_cyc = cyc;
    end
    if (m_active && cyc == m_ack) begin
      m_active    = 1'b0;
      m_free_from = cyc + 1;
      m_ptr       = (m_w + 1) % N;
      req[m_w]    = 1'b0;
      hold[m_w]   = cyc + 2;
    end
  endtask

  task automatic stimulus();
    if (stim_mode == 2 && m_active && cyc > m_t) begin
      // Late operand changes and mid-job withdrawal must not disturb the job.
      if ($urandom_range(15) == 0) a_bus[m_w*W +: W] = W'($urandom);
      if ($urandom_range(31) == 0) begin
        req[m_w]  = 1'b0;
        hold[m_w] = m_ack + 2;
      end
    end
    if (stim_mode != 0) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && hold[i] <= cyc && (stim_mode == 1 || $urandom_range(3) == 0)) begin
          a_bus[i*W +: W] = W'($urandom);
          req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    model_arbitrate();
    @(negedge clk);
    check();
    stimulus();
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((m_active || cyc < m_free_from) && g < 300) begin
      step();
      g++;
    end
    if (m_active || cyc < m_free_from) cmp_val("wait_idle_bound", 1, 0);
  endtask

  task automatic wait_ack();
    int n0 = dut_ack_cnt;
    int g = 0;
    while (dut_ack_cnt == n0 && g < 300) begin
      step();
      g++;
    end
    if (dut_ack_cnt == n0) begin
      cmp_val("ack_wait_bound", 1, 0);
      last_ack = '0;
    end
  endtask

  task automatic run_single(input int k);
    int t0;
    wait_idle();
    a_bus[tbl[k].idx*W +: W] = W'(tbl[k].a);
    req[tbl[k].idx] = 1'b1;
    next_delay = tbl[k].d;
    t0 = cyc;
    wait_ack();
    cmp_val($sformatf("tbl%0d_ack", k), int'(last_ack), 1 << tbl[k].idx);
    cmp_val($sformatf("tbl%0d_res", k), int'(last_res), tbl[k].exp_res);
    cmp_val($sformatf("tbl%0d_err", k), int'(last_err), tbl[k].exp_err);
    cmp_val($sformatf("tbl%0d_lat", k), last_cyc - t0, tbl[k].exp_lat);
  endtask

  int order[5];

  initial begin
    tbl[0] = '{0, 144,     20, 12,  0, 24};
    tbl[1] = '{1, 0,       5,  0,   0, 9};
    tbl[2] = '{2, 'hFFFF,  1,  255, 0, 5};
    tbl[3] = '{3, 1,       63, 1,   0, 67};
    tbl[4] = '{0, 100,     -1, 0,   1, 67};
    tbl[5] = '{1, 15,      10, 3,   0, 14};
    tbl[6] = '{2, 50,      64, 0,   1, 67};
    order  = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clk);
    cmp_val("reset_outputs", int'({ack, err, res, busy, raiz_rst, raiz_init, raiz_A}),
            int'({4'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0}));
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_single(k);

    // Pointer now sits at 3: requesters 1 and 2 contend, 1 wins after the wrap.
    wait_idle();
    a_bus[1*W +: W] = 16'd49;
    a_bus[2*W +: W] = 16'd81;
    req[1] = 1'b1;
    req[2] = 1'b1;
    next_delay = 2;
    wait_ack();
    cmp_val("wrap_winner", int'(last_ack), 2);
    cmp_val("wrap_res", int'(last_res), 7);
    wait_ack();
    cmp_val("wrap_second", int'(last_ack), 4);
    cmp_val("wrap_second_res", int'(last_res), 9);

    // Reset in the middle of a stalled job.
    wait_idle();
    a_bus[0 +: W] = 16'd1234;
    req[0] = 1'b1;
    next_delay = -1;
    repeat (8) step();
    rst = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    cmp_val("rst_midwait", int'({ack, err, res, busy, raiz_rst, raiz_init, raiz_A}),
            int'({4'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0}));
    rst = 1'b0;
    m_active = 1'b0;
    m_ptr = 0;
    m_lastA = '0;
    m_free_from = cyc;
    a_bus[1*W +: W] = 16'd1024;
    a_bus[3*W +: W] = 16'd400;
    req[1] = 1'b1;
    req[3] = 1'b1;
    next_delay = 7;
    wait_ack();
    cmp_val("post_rst_winner", int'(last_ack), 2);
    cmp_val("post_rst_res", int'(last_res), 32);
    wait_ack();
    cmp_val("post_rst_second", int'(last_ack), 8);
    cmp_val("post_rst_second_res", int'(last_res), 20);

    // Fairness: everyone keeps requesting.
    wait_idle();
    next_delay = 3;
    stim_mode = 1;
    for (int i = 0; i < N; i++) a_bus[i*W +: W] = W'((i + 2) * (i + 2));
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack();
      cmp_val($sformatf("rr_order%0d", k), int'(last_ack), 1 << order[k]);
    end

    stim_mode = 2;
    next_delay = -2;
    repeat (2500) step();
    stim_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
